// File: rtl/axi_rd_stride_splitter.sv
// AXI4 read splitter: cuts INCR bursts at STRIDE boundaries and re-merges R beats into one burst.
// Optional RRESP_STICKY_EN: the first error response of a burst persists on every later beat.
module axi_rd_stride_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRIDE     = 'h2000
) (
  input  logic                  AXI_aclk,
  input  logic                  AXI_aresetn,
  input  logic [ADDR_WIDTH-1:0] S_AXI_araddr,
  input  logic [7:0]            S_AXI_arlen,
  input  logic [2:0]            S_AXI_arsize,
  input  logic [1:0]            S_AXI_arburst,
  input  logic [ID_WIDTH-1:0]   S_AXI_arid,
  input  logic [1:0]            S_AXI_arlock,
  input  logic [3:0]            S_AXI_arcache,
  input  logic [2:0]            S_AXI_arprot,
  input  logic [3:0]            S_AXI_arregion,
  input  logic [3:0]            S_AXI_arqos,
  input  logic                  S_AXI_arvalid,
  output logic                  S_AXI_arready,
  output logic [DATA_WIDTH-1:0] S_AXI_rdata,
  output logic [1:0]            S_AXI_rresp,
  output logic [ID_WIDTH-1:0]   S_AXI_rid,
  output logic                  S_AXI_rlast,
  output logic                  S_AXI_rvalid,
  input  logic                  S_AXI_rready,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [1:0]            M_AXI_arlock,
  output logic [3:0]            M_AXI_arcache,
  output logic [2:0]            M_AXI_arprot,
  output logic [3:0]            M_AXI_arregion,
  output logic [3:0]            M_AXI_arqos,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A    = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_MASK = ADDR_WIDTH'(STRIDE - 1);

  logic [1:0]            state_q, state_d;
  logic                  arready_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            rem_q, rem_d;
  logic [8:0]            issued_q, issued_d;
  logic [8:0]            done_q, done_d;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            lock_q;
  logic [3:0]            cache_q;
  logic [2:0]            prot_q;
  logic [3:0]            region_q;
  logic [3:0]            qos_q;

  logic [ADDR_WIDTH-1:0] aligned, bytes_to_bnd, bnd_beats, next_addr;
  logic [8:0]            sub_beats;
  logic                  ar_hs_s, ar_hs_m, r_hs, unused_rid;

  // Stray downstream beats outside a burst (e.g. after a reset) never reach the initiator.
  assign S_AXI_rvalid = M_AXI_rvalid & (state_q != ST_IDLE);
  assign M_AXI_rready = S_AXI_rready;
  assign S_AXI_rdata  = M_AXI_rdata;
  assign S_AXI_rid    = id_q;
  assign S_AXI_rlast  = M_AXI_rlast & (state_q == ST_DRAIN) & (done_q == issued_q - 9'd1);
  assign unused_rid   = ^M_AXI_rid;

  assign S_AXI_arready = arready_q;
  assign ar_hs_s = S_AXI_arvalid & arready_q;
  assign ar_hs_m = (state_q == ST_ISSUE) & M_AXI_arready;
  assign r_hs    = S_AXI_rvalid & S_AXI_rready;

  assign aligned      = addr_q & ~((ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1));
  assign bytes_to_bnd = STRIDE_A - (aligned & STRIDE_MASK);
  assign bnd_beats    = bytes_to_bnd >> size_q;
  assign sub_beats    = ((burst_q == BURST_INCR) && (bnd_beats < ADDR_WIDTH'(rem_q)))
                        ? bnd_beats[8:0] : rem_q;
  assign next_addr    = aligned + (ADDR_WIDTH'(sub_beats) << size_q);

  assign M_AXI_arvalid  = (state_q == ST_ISSUE);
  assign M_AXI_araddr   = addr_q;
  assign M_AXI_arlen    = 8'(sub_beats - 9'd1);
  assign M_AXI_arsize   = size_q;
  assign M_AXI_arburst  = burst_q;
  assign M_AXI_arid     = id_q;
  assign M_AXI_arlock   = lock_q;
  assign M_AXI_arcache  = cache_q;
  assign M_AXI_arprot   = prot_q;
  assign M_AXI_arregion = region_q;
  assign M_AXI_arqos    = qos_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    issued_d = issued_q;
    done_d   = done_q;
    if (r_hs && M_AXI_rlast) done_d = done_q + 9'd1;
    case (state_q)
      ST_IDLE: if (ar_hs_s) begin
        addr_d   = S_AXI_araddr;
        rem_d    = 9'(S_AXI_arlen) + 9'd1;
        issued_d = '0;
        done_d   = '0;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: if (ar_hs_m) begin
        addr_d   = next_addr;
        rem_d    = rem_q - sub_beats;
        issued_d = issued_q + 9'd1;
        if (rem_q == sub_beats) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (r_hs && S_AXI_rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      issued_q  <= '0;
      done_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      id_q      <= '0;
      lock_q    <= '0;
      cache_q   <= '0;
      prot_q    <= '0;
      region_q  <= '0;
      qos_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      if (ar_hs_s) begin
        size_q   <= S_AXI_arsize;
        burst_q  <= S_AXI_arburst;
        id_q     <= S_AXI_arid;
        lock_q   <= S_AXI_arlock;
        cache_q  <= S_AXI_arcache;
        prot_q   <= S_AXI_arprot;
        region_q <= S_AXI_arregion;
        qos_q    <= S_AXI_arqos;
      end
    end
  end

`ifdef RRESP_STICKY_EN
  logic [1:0] resp_q;

  // Numeric order of the response codes doubles as severity order.
  assign S_AXI_rresp = (resp_q > M_AXI_rresp) ? resp_q : M_AXI_rresp;

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      resp_q <= 2'b00;
    end else if (state_q == ST_IDLE) begin
      resp_q <= 2'b00;
    end else if (r_hs && (resp_q == 2'b00) && (M_AXI_rresp != 2'b00)) begin
      resp_q <= M_AXI_rresp;
    end
  end
`else
  assign S_AXI_rresp = M_AXI_rresp;
`endif

endmodule

// File: tb/tb_axi_rd_stride_splitter.sv
// Self-checking bench for axi_rd_stride_splitter: vector table, reset-in-DRAIN sequence, random bursts.
// Expected sub-ARs come from a plain-arithmetic split model; a slave model returns R beats.
module tb_axi_rd_stride_splitter;
  localparam int STRIDE = 'h2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic [3:0]  s_arid = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [3:0]  s_rid;
  logic        s_rlast, s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic [1:0]  m_arlock;
  logic [3:0]  m_arcache, m_arregion, m_arqos;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic [3:0]  m_rid = '0;
  logic        m_rlast = 1'b0, m_rvalid = 1'b0;
  logic        m_rready;

  int n_cmp = 0;
  int n_err = 0;
  int burst_no = 0;
  logic [31:0] exp_a[$];
  int          exp_l[$];
  int          pend[$];

  always #5 clk = ~clk;

  axi_rd_stride_splitter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .STRIDE(STRIDE)) dut (
    .AXI_aclk(clk), .AXI_aresetn(rst_n),
    .S_AXI_araddr(s_araddr), .S_AXI_arlen(s_arlen), .S_AXI_arsize(s_arsize),
    .S_AXI_arburst(s_arburst), .S_AXI_arid(s_arid), .S_AXI_arlock(2'b01),
    .S_AXI_arcache(4'h3), .S_AXI_arprot(3'h2), .S_AXI_arregion(4'h5), .S_AXI_arqos(4'hA),
    .S_AXI_arvalid(s_arvalid), .S_AXI_arready(s_arready),
    .S_AXI_rdata(s_rdata), .S_AXI_rresp(s_rresp), .S_AXI_rid(s_rid),
    .S_AXI_rlast(s_rlast), .S_AXI_rvalid(s_rvalid), .S_AXI_rready(s_rready),
    .M_AXI_araddr(m_araddr), .M_AXI_arlen(m_arlen), .M_AXI_arsize(m_arsize),
    .M_AXI_arburst(m_arburst), .M_AXI_arid(m_arid), .M_AXI_arlock(m_arlock),
    .M_AXI_arcache(m_arcache), .M_AXI_arprot(m_arprot), .M_AXI_arregion(m_arregion),
    .M_AXI_arqos(m_arqos), .M_AXI_arvalid(m_arvalid), .M_AXI_arready(m_arready),
    .M_AXI_rdata(m_rdata), .M_AXI_rresp(m_rresp), .M_AXI_rid(m_rid),
    .M_AXI_rlast(m_rlast), .M_AXI_rvalid(m_rvalid), .M_AXI_rready(m_rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (burst %0d, t=%0t)", name, act, exp, burst_no, $time);
    end
  endtask

  // Split a burst into stride-bounded pieces: walk the byte range, cutting at each multiple of STRIDE.
  task automatic model(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst);
    longint cur, beat, room;
    int rem, n;
    exp_a.delete();
    exp_l.delete();
    if (burst != 2'b01) begin
      exp_a.push_back(addr);
      exp_l.push_back(len);
      return;
    end
    beat = longint'(1) << size;
    cur  = addr;
    rem  = len + 1;
    while (rem > 0) begin
      room = (STRIDE - ((cur / beat) * beat) % STRIDE) / beat;
      n = (rem < room) ? rem : int'(room);
      exp_a.push_back(32'(cur));
      exp_l.push_back(n - 1);
      cur = (cur / beat) * beat + n * beat;
      rem -= n;
    end
  endtask

  function automatic logic [31:0] beat_data(input int b);
    return 32'hD000_0000 | (32'(burst_no) << 12) | 32'(b);
  endfunction

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int hold,
                           input int err_beat, input int nsubs, input bit abort);
    int sub_idx = 0, hold_cnt = 0, beat = 0, sub_beat = 0, cycles = 0, total;
    bit ar_sent = 0, done = 0, sticky = 0;
    logic [1:0] first_bad = 2'b00, cur_resp, exp_resp;
`ifdef RRESP_STICKY_EN
    sticky = 1;
`endif
    burst_no++;
    model(addr, int'(len), int'(size), burst);
    total = int'(len) + 1;
    pend.delete();
    @(negedge clk);
    s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arid = id;
    while (!done) begin
      s_arvalid = !ar_sent;
      m_arready = (hold_cnt >= hold);
      cur_resp  = (beat == err_beat) ? 2'b10 : 2'b00;
      m_rvalid  = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
      m_rdata   = beat_data(beat);
      m_rlast   = (pend.size() > 0) && (sub_beat == pend[0] - 1);
      m_rresp   = cur_resp;
      m_rid     = ~id;
      s_rready  = ($urandom_range(0, 3) != 0);
      #1;
      if (ar_sent) chk("s_arready_busy", s_arready, 0);
      else if (s_arready) ar_sent = 1;
      if (m_arvalid) begin
        if (sub_idx >= exp_a.size()) chk("extra_sub_ar", m_arvalid, 0);
        else begin
          chk("m_araddr", m_araddr, exp_a[sub_idx]);
          chk("m_arlen", m_arlen, exp_l[sub_idx]);
          chk("m_arctl", {m_arsize, m_arburst, m_arid}, {size, burst, id});
          chk("m_arside", {m_arlock, m_arcache, m_arprot, m_arregion, m_arqos},
              {2'b01, 4'h3, 3'h2, 4'h5, 4'hA});
          if (m_arready) begin
            pend.push_back(exp_l[sub_idx] + 1);
            sub_idx++;
            hold_cnt = 0;
          end else hold_cnt++;
        end
      end
      if (m_rvalid && s_rready) begin
        exp_resp = cur_resp;
        if (sticky && first_bad > exp_resp) exp_resp = first_bad;
        if (first_bad == 2'b00) first_bad = cur_resp;
        chk("m_rready", m_rready, 1);
        chk("s_rvalid", s_rvalid, 1);
        chk("s_rdata", s_rdata, beat_data(beat));
        chk("s_rid", s_rid, id);
        chk("s_rlast", s_rlast, beat == total - 1);
        chk("s_rresp", s_rresp, exp_resp);
        beat++;
        sub_beat++;
        if (sub_beat == pend[0]) begin
          void'(pend.pop_front());
          sub_beat = 0;
        end
        if (beat == total) done = 1;
      end
      if (abort && sub_idx == exp_a.size() && beat >= 4) done = 1;
      cycles++;
      if (cycles > 6000) begin
        chk("timeout_beats", beat, total);
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    if (abort) return;
    @(negedge clk);
    s_arvalid = 0; m_rvalid = 0; m_rlast = 0; m_arready = 0;
    #1;
    if (nsubs >= 0) chk("n_sub_ars", sub_idx, nsubs);
    chk("arready_after", s_arready, 1);
    chk("s_rvalid_idle", s_rvalid, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          hold;
    int          err_beat;
    int          nsubs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'h1F80, 8'd7,   3'd6, 2'b01, 0, -1, 2};  // split 2+6
    tbl[1] = '{32'h0000, 8'd15,  3'd6, 2'b01, 1, -1, 1};  // no crossing
    tbl[2] = '{32'h1FC0, 8'd3,   3'd6, 2'b10, 0, -1, 1};  // WRAP
    tbl[3] = '{32'h1000, 8'd255, 3'd6, 2'b01, 5, -1, 3};  // 64/128/64 with held arready
    tbl[4] = '{32'h1F80, 8'd7,   3'd6, 2'b01, 2, 1, 2};   // SLVERR on beat 2
    tbl[5] = '{32'h1FF0, 8'd7,   3'd2, 2'b00, 0, -1, 1};  // FIXED
    tbl[6] = '{32'h1E00, 8'd7,   3'd6, 2'b01, 0, -1, 1};  // ends exactly on boundary
    tbl[7] = '{32'h1FFE, 8'd3,   3'd2, 2'b01, 1, 0, 2};   // unaligned start, 1-beat head

    m_rvalid = 1; m_rlast = 1; s_rready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arready", s_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_s_rlast", s_rlast, 0);
    m_rvalid = 0; m_rlast = 0;
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("arready_post_rst", s_arready, 1);

    for (int i = 0; i < 8; i++)
      run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i + 3),
                tbl[i].hold, tbl[i].err_beat, tbl[i].nsubs, 0);

    // Reset while the long burst is draining
    run_burst(32'h1000, 8'd255, 3'd6, 2'b01, 4'h9, 0, -1, 3, 1);
    @(negedge clk);
    rst_n = 0; m_rvalid = 1; m_rlast = 1; s_rready = 1; m_arready = 1; s_arvalid = 1;
    #1;
    chk("midrst_arready", s_arready, 0);
    chk("midrst_m_arvalid", m_arvalid, 0);
    chk("midrst_s_rvalid", s_rvalid, 0);
    chk("midrst_s_rlast", s_rlast, 0);
    @(negedge clk);
    #1;
    chk("midrst_arready_hold", s_arready, 0);
    rst_n = 1; m_rvalid = 0; m_rlast = 0; s_arvalid = 0;
    @(negedge clk);
    #1;
    chk("arready_post_midrst", s_arready, 1);
    run_burst(32'h0000, 8'd15, 3'd6, 2'b01, 4'h6, 0, -1, 1, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [1:0]  b;
      logic [7:0]  l;
      a = 32'($urandom_range(0, 32'hFFFF));
      b = ($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom_range(0, 2));
      l = 8'($urandom_range(0, (i % 4 == 0) ? 255 : 63));
      run_burst(a, l, 3'($urandom_range(0, 7)), b, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), int'($urandom_range(0, 80)) - 10, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
